xor_frame_acc: RTL and testbench

//   Parametrised successor to the single-bit XOR gate: a clocked XOR

---
 rtl/xor_frame_acc_if.sv | 24 ++
 rtl/xor_frame_acc.sv | 80 ++++++++
 tb/tb_xor_frame_acc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/xor_frame_acc_if.sv
// xor_frame_acc_if: word stream in, folded frame result out
interface xor_frame_acc_if #(
  parameter int WIDTH = 8,
  parameter int FRAME_LEN = 4
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             odd_mode;
  logic             abort;
  logic [CNT_W-1:0] word_cnt;
  logic             out_valid;
  logic [WIDTH-1:0] out_word;
  logic             out_parity;
  modport master (
    output in_valid, in_data, odd_mode, abort,
    input  in_ready, word_cnt, out_valid, out_word, out_parity
  );
  modport slave (
    input  in_valid, in_data, odd_mode, abort,
    output in_ready, word_cnt, out_valid, out_word, out_parity
  );
endinterface

// File: rtl/xor_frame_acc.sv
// xor_frame_acc: XOR-folds FRAME_LEN stream words into one word plus even/odd parity
module xor_frame_acc #(
  parameter int WIDTH = 8,
  parameter int FRAME_LEN = 4,
  localparam int CNT_W = $clog2(FRAME_LEN + 1)
) (
  input logic            clk,
  input logic            rst,
  xor_frame_acc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d, par_q, par_d;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    word_d  = word_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (bus.abort) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (bus.in_valid) begin
          acc_d   = bus.in_data;
          mode_d  = bus.odd_mode;
          cnt_d   = CNT_W'(1);
          state_d = (FRAME_LEN == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (bus.abort) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (bus.in_valid) begin
          acc_d   = acc_q ^ bus.in_data;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_W'(FRAME_LEN - 1)) ? DONE : ACC;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // result registers load on the edge entering DONE so they line up with out_valid
    if (state_d == DONE && state_q != DONE) begin
      word_d = acc_d;
      par_d  = (^acc_d) ^ mode_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      word_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      par_q   <= par_d;
    end
  end
  assign bus.in_ready   = (state_q != DONE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.word_cnt   = cnt_q;
  assign bus.out_word   = word_q;
  assign bus.out_parity = par_q;
endmodule

// File: tb/tb_xor_frame_acc.sv
// tb_xor_frame_acc: frame-level reference model with scoreboard for xor_frame_acc
module tb_xor_frame_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  xor_frame_acc_if #(.WIDTH(8), .FRAME_LEN(4)) ia ();
  xor_frame_acc_if #(.WIDTH(4), .FRAME_LEN(1)) ib ();
  xor_frame_acc #(.WIDTH(8), .FRAME_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  xor_frame_acc #(.WIDTH(4), .FRAME_LEN(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb_q[$];
  logic [7:0] fr_q[$];
  bit         mode_m, done_m;
  logic [7:0] last_w;
  logic       last_p;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (ia.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("out_word", ia.out_word, e[7:0]);
        chk("out_parity", ia.out_parity, e[8]);
      end
    end
  end
  task automatic do_rst(int n);
    rst = 1'b1;
    ia.in_valid = 0; ia.in_data = 0; ia.odd_mode = 0; ia.abort = 0;
    ib.in_valid = 0; ib.in_data = 0; ib.odd_mode = 0; ib.abort = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    fr_q.delete();
    sb_q.delete();
    done_m = 0; mode_m = 0; last_w = 0; last_p = 0;
  endtask
  // one cycle on DUT A: check current outputs against the model, then apply inputs
  task automatic step(bit v, logic [7:0] d, bit m, bit a);
    logic [7:0] x;
    chk("in_ready", ia.in_ready, !done_m);
    chk("out_valid", ia.out_valid, done_m);
    chk("word_cnt", ia.word_cnt, fr_q.size());
    if (!done_m) begin
      chk("hold_word", ia.out_word, last_w);
      chk("hold_parity", ia.out_parity, last_p);
    end
    ia.in_valid = v; ia.in_data = d; ia.odd_mode = m; ia.abort = a;
    if (done_m) begin
      done_m = 0;
      fr_q.delete();
    end else if (a) begin
      fr_q.delete();
    end else if (v) begin
      if (fr_q.size() == 0) mode_m = m;
      fr_q.push_back(d);
      if (fr_q.size() == 4) begin
        x = '0;
        foreach (fr_q[i]) x = x ^ fr_q[i];
        last_w = x;
        last_p = (^x) ^ mode_m;
        sb_q.push_back({last_p, last_w});
        done_m = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic frame(logic [7:0] w0, w1, w2, w3, bit m);
    step(1, w0, m, 0); step(1, w1, m, 0); step(1, w2, m, 0); step(1, w3, m, 0);
  endtask
  initial begin
    do_rst(3);
    chk("rst_out_word", ia.out_word, 0);
    chk("rst_out_parity", ia.out_parity, 0);
    step(0, 0, 0, 0);
    frame(8'h01, 8'h02, 8'h04, 8'h08, 0);
    chk("even_word", ia.out_word, 8'h0F);
    chk("even_parity", ia.out_parity, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 8'hFF, 1, 0); step(0, 0, 0, 0);
    step(1, 8'h0F, 0, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(1, 8'h00, 0, 0); step(0, 0, 0, 0);
    step(1, 8'h01, 0, 0);
    chk("odd_word", ia.out_word, 8'hF1);
    chk("odd_parity", ia.out_parity, 0);
    chk("odd_cnt4", ia.word_cnt, 4);
    step(0, 0, 0, 0);
    step(1, 8'hAA, 0, 0); step(1, 8'h55, 0, 0); step(1, 8'h33, 0, 1);
    chk("abort_cnt", ia.word_cnt, 0);
    step(0, 0, 0, 0);
    frame(8'h10, 8'h20, 8'h40, 8'h80, 0);
    chk("post_abort_word", ia.out_word, 8'hF0);
    step(1, 8'h77, 0, 1);
    frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
    step(1, 8'h99, 0, 0);
    step(1, 8'h12, 0, 0); step(1, 8'h34, 0, 0);
    do_rst(1);
    step(0, 0, 0, 0);
    frame(8'h5A, 8'hC3, 8'h0F, 8'h81, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!done_m && $urandom_range(63) == 0) do_rst(1);
      step($urandom_range(3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(15) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sb_drained", sb_q.size(), 0);
    do_rst(2);
    ib.in_valid = 1; ib.in_data = 4'h3; ib.odd_mode = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("b_out_valid", ib.out_valid, (k % 2) == 0);
      chk("b_in_ready", ib.in_ready, (k % 2) != 0);
      if (k % 2 == 0) begin
        chk("b_out_word", ib.out_word, 4'h3);
        chk("b_out_parity", ib.out_parity, 0);
      end
    end
    ib.in_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
